// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider tile.
package seq_divider_pkg;

   localparam int WIDTH = 4;
   localparam int CNT_W = $clog2(WIDTH);

   localparam int START_BIT = 0;
   localparam int BUSY_BIT  = 1;
   localparam int DONE_BIT  = 2;
   localparam int DBZ_BIT   = 3;
   localparam int OVF_BIT   = 4;

   localparam logic [7:0] UIO_OE_VAL = 8'b0001_1110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
import seq_divider_pkg::*;

module div_step (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             unused_bits;

   // One extra bit beyond the shifted value so the borrow lands in the MSB.
   assign shifted     = {rem_in, next_bit};
   assign diff        = {1'b0, shifted} - {2'b00, divisor};
   assign q_bit       = ~diff[WIDTH+1];
   assign rem_out     = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign unused_bits = &{1'b0, diff[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/tt_um_seq_divider_hhrb98.sv
// TinyTapeout 4-bit sequential restoring divider with start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
import seq_divider_pkg::*;

module tt_um_seq_divider_hhrb98 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Handshake: start is a level sampled on clk when ena=1; it is accepted only in
   // IDLE or DONE. busy is high from acceptance until the result loads; done is high
   // while the result is held in DONE.
   state_t           state, state_d;
   logic             accept;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem_q, dvd_q, dsr_mag, dvd_raw, dsr_raw;
   logic [WIDTH-1:0] rem_next, dvd_mag_in, dsr_mag_in, q_fix, r_fix;
   logic             q_bit, ovf_fix, dbz_q, ovf_q;
   logic [7:0]       result_q;
   logic             unused_ok;

   assign unused_ok = &{1'b0, uio_in[7:1]};

   div_step u_step (
      .rem_in  (rem_q),
      .next_bit(dvd_q[WIDTH-1]),
      .divisor (dsr_mag),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvd_mag_in = ui_in[3] ? (~ui_in[3:0] + 4'd1) : ui_in[3:0];
      dsr_mag_in = ui_in[7] ? (~ui_in[7:4] + 4'd1) : ui_in[7:4];
      q_fix      = (dvd_raw[WIDTH-1] ^ dsr_raw[WIDTH-1]) ? (~dvd_q + 4'd1) : dvd_q;
      r_fix      = dvd_raw[WIDTH-1] ? (~rem_q + 4'd1) : rem_q;
      ovf_fix    = (dvd_raw == 4'b1000) && (dsr_raw == 4'b1111);
`else
      dvd_mag_in = ui_in[3:0];
      dsr_mag_in = ui_in[7:4];
      q_fix      = dvd_q;
      r_fix      = rem_q;
      ovf_fix    = 1'b0;
`endif
   end

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (uio_in[START_BIT]) begin
               accept  = 1'b1;
               state_d = (ui_in[7:4] == '0) ? FIX : CALC;
            end
         end
         CALC:    if (count == '0) state_d = FIX;
         FIX:     state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state <= IDLE;
      else if (ena) state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dsr_mag  <= '0;
         dvd_raw  <= '0;
         dsr_raw  <= '0;
         dbz_q    <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
      end else if (ena) begin
         if (accept) begin
            dvd_raw <= ui_in[3:0];
            dsr_raw <= ui_in[7:4];
            dvd_q   <= dvd_mag_in;
            dsr_mag <= dsr_mag_in;
            rem_q   <= '0;
            count   <= CNT_W'(WIDTH - 1);
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
         end else if (state == CALC) begin
            // Quotient bits shift into the vacated LSBs of the dividend register.
            rem_q <= rem_next;
            dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
            count <= count - 1'b1;
         end else if (state == FIX) begin
            if (dsr_raw == '0) begin
               result_q <= {dvd_raw, 4'hF};
               dbz_q    <= 1'b1;
            end else begin
               result_q <= {r_fix, q_fix};
               ovf_q    <= ovf_fix;
            end
         end
      end
   end

   assign uo_out  = result_q;
   assign uio_out = {3'b000, ovf_q, dbz_q, (state == DONE),
                     (state == CALC) || (state == FIX), 1'b0};
   assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// Directed bench for the sequential divider; signed cases enabled with SEQ_DIVIDER_SIGNED_EN.
module tb_tt_um_seq_divider_hhrb98;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_tests = 0;
   int n_fail  = 0;

   tt_um_seq_divider_hhrb98 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches a={dividend}, b={divisor}; lat counts edges from acceptance to done.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int drop_at,
                         input int restart_at, output int lat, output int busy_cnt,
                         output logic [7:0] first_uo);
      @(negedge clk);
      ui_in     = {b, a};
      uio_in[0] = 1'b1;
      @(negedge clk);
      uio_in[0] = 1'b0;
      ui_in     = 8'h00;
      first_uo  = uo_out;
      lat       = 0;
      busy_cnt  = 0;
      while (!uio_out[2] && lat < 40) begin
         if (uio_out[1]) busy_cnt++;
         if (lat == drop_at) ena = 1'b0;
         if (lat == drop_at + 3) ena = 1'b1;
         if (lat == restart_at) begin
            ui_in     = 8'h26;
            uio_in[0] = 1'b1;
         end else begin
            uio_in[0] = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      ena       = 1'b1;
      uio_in[0] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      #12;
      n_tests++;
      if (uo_out !== 8'h00) begin
         n_fail++; $display("FAIL reset_uo got=%h exp=00", uo_out);
      end
      n_tests++;
      if (uio_out !== 8'h00) begin
         n_fail++; $display("FAIL reset_uio got=%h exp=00", uio_out);
      end
      n_tests++;
      if (uio_oe !== 8'h1E) begin
         n_fail++; $display("FAIL uio_oe got=%h exp=1e", uio_oe);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat, bc;
      logic [7:0] fu;
      run_op(4'd13, 4'd3, -1, -1, lat, bc, fu);
      n_tests++;
      if (uo_out !== 8'h14) begin
         n_fail++; $display("FAIL basic_13_3 got=%h exp=14", uo_out);
      end
      n_tests++;
      if (lat !== 5) begin
         n_fail++; $display("FAIL basic_latency got=%0d exp=5", lat);
      end
      n_tests++;
      if (bc !== 5) begin
         n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc);
      end
      n_tests++;
      if (uio_out !== 8'h04) begin
         n_fail++; $display("FAIL basic_flags got=%h exp=04", uio_out);
      end
      run_op(4'd8, 4'd15, -1, -1, lat, bc, fu);
      n_tests++;
      if (fu !== 8'h14) begin
         n_fail++; $display("FAIL hold_old_result got=%h exp=14", fu);
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      n_tests++;
      if ({uio_out, uo_out} !== 16'h1408) begin
         n_fail++; $display("FAIL signed_m8_m1 got=%h exp=1408", {uio_out, uo_out});
      end
      run_op(4'b1001, 4'd2, -1, -1, lat, bc, fu);
      n_tests++;
      if ({uio_out, uo_out} !== 16'h04FD) begin
         n_fail++; $display("FAIL signed_m7_2 got=%h exp=04fd", {uio_out, uo_out});
      end
`else
      n_tests++;
      if ({uio_out, uo_out} !== 16'h0480) begin
         n_fail++; $display("FAIL unsigned_8_15 got=%h exp=0480", {uio_out, uo_out});
      end
`endif
   endtask

   task automatic test_div_by_zero();
      int lat, bc;
      logic [7:0] fu;
      run_op(4'd5, 4'd0, -1, -1, lat, bc, fu);
      n_tests++;
      if (uo_out !== 8'h5F) begin
         n_fail++; $display("FAIL dbz_result got=%h exp=5f", uo_out);
      end
      n_tests++;
      if (lat !== 1) begin
         n_fail++; $display("FAIL dbz_latency got=%0d exp=1", lat);
      end
      n_tests++;
      if (bc !== 1) begin
         n_fail++; $display("FAIL dbz_busy_cycles got=%0d exp=1", bc);
      end
      n_tests++;
      if (uio_out !== 8'h0C) begin
         n_fail++; $display("FAIL dbz_flags got=%h exp=0c", uio_out);
      end
   endtask

   task automatic test_ignore_start();
      int lat, bc;
      logic [7:0] fu;
      run_op(4'd15, 4'd1, -1, 1, lat, bc, fu);
      n_tests++;
      if (uo_out !== 8'h0F) begin
         n_fail++; $display("FAIL ignore_start got=%h exp=0f", uo_out);
      end
      n_tests++;
      if (lat !== 5) begin
         n_fail++; $display("FAIL ignore_latency got=%0d exp=5", lat);
      end
      n_tests++;
      if (uio_out[3] !== 1'b0) begin
         n_fail++; $display("FAIL dbz_cleared got=%b exp=0", uio_out[3]);
      end
      run_op(4'd6, 4'd2, -1, -1, lat, bc, fu);
      n_tests++;
      if (fu !== 8'h0F) begin
         n_fail++; $display("FAIL old_visible got=%h exp=0f", fu);
      end
      n_tests++;
      if (uo_out !== 8'h03) begin
         n_fail++; $display("FAIL restart_6_2 got=%h exp=03", uo_out);
      end
   endtask

   task automatic test_ena_stall();
      int lat, bc;
      logic [7:0] fu;
      run_op(4'd13, 4'd3, 1, -1, lat, bc, fu);
      n_tests++;
      if (lat !== 8) begin
         n_fail++; $display("FAIL ena_latency got=%0d exp=8", lat);
      end
      n_tests++;
      if (uo_out !== 8'h14) begin
         n_fail++; $display("FAIL ena_result got=%h exp=14", uo_out);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ui_in     = {4'd3, 4'd13};
      uio_in[0] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 40 && !uio_out[2]; i++) @(negedge clk);
      n_tests++;
      if (uo_out !== 8'h14 || uio_out[2] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_first got=%h/%b exp=14/1", uo_out, uio_out[2]);
      end
      ui_in = {4'd4, 4'd9};
      @(negedge clk);
      n_tests++;
      if (uio_out[2:1] !== 2'b01) begin
         n_fail++; $display("FAIL b2b_relaunch got=%b exp=01", uio_out[2:1]);
      end
      uio_in[0] = 1'b0;
      for (int i = 0; i < 40 && !uio_out[2]; i++) @(negedge clk);
      n_tests++;
      if (uo_out !== 8'h12) begin
         n_fail++; $display("FAIL b2b_second got=%h exp=12", uo_out);
      end
   endtask

   task automatic test_mid_reset();
      int lat, bc;
      logic [7:0] fu;
      @(negedge clk);
      ui_in     = {4'd3, 4'd13};
      uio_in[0] = 1'b1;
      @(negedge clk);
      uio_in[0] = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         n_fail++; $display("FAIL mid_reset got=%h/%h exp=00/00", uo_out, uio_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (uio_out !== 8'h00) begin
         n_fail++; $display("FAIL post_reset_idle got=%h exp=00", uio_out);
      end
      run_op(4'd9, 4'd4, -1, -1, lat, bc, fu);
      n_tests++;
      if (uo_out !== 8'h12) begin
         n_fail++; $display("FAIL post_reset_9_4 got=%h exp=12", uo_out);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_by_zero();
      test_ignore_start();
      test_ena_stall();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
